// File: rtl/result_deserializer.sv
// Serial-to-parallel result deserializer: 32-bit MSB-first frames into C00..C11.
// Optional frame checking with DRAIN state: define RESULT_DESER_FRAME_CHECK_EN.
module result_deserializer (
  input  logic       clk,
  input  logic       nRST,
  input  logic       serial_in,
  input  logic       recieve,
  input  logic       result_ack,
  output logic [7:0] C00,
  output logic [7:0] C01,
  output logic [7:0] C10,
  output logic [7:0] C11,
  output logic       result_valid,
  output logic       overrun,
  output logic       frame_err,
  output logic       busy
);

`ifdef RESULT_DESER_FRAME_CHECK_EN
  typedef enum logic [1:0] {IDLE, SHIFT, DRAIN} state_t;
`else
  typedef enum logic [0:0] {IDLE, SHIFT} state_t;
`endif

  state_t      state, state_nxt;
  logic [4:0]  count, count_nxt;
  logic [31:0] sr, sr_nxt;
  logic        done;
`ifdef RESULT_DESER_FRAME_CHECK_EN
  logic        err;
`endif

  // State register; reset wins over everything.
  always_ff @(posedge clk) begin
    if (!nRST) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state, shift and frame-completion decode.
  // After completion SHIFT is held with count=0 so the next edge can
  // tell a clean stop from a frame that runs long.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    sr_nxt    = sr;
    done      = 1'b0;
`ifdef RESULT_DESER_FRAME_CHECK_EN
    err       = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (recieve) begin
          sr_nxt    = {31'd0, serial_in};
          count_nxt = 5'd1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (recieve) begin
`ifdef RESULT_DESER_FRAME_CHECK_EN
          if (count == 5'd0) begin
            err       = 1'b1;
            state_nxt = DRAIN;
          end else begin
`else
          begin
`endif
            sr_nxt    = {sr[30:0], serial_in};
            count_nxt = count + 5'd1;
            done      = (count == 5'd31);
          end
        end else begin
          state_nxt = IDLE;
          count_nxt = 5'd0;
`ifdef RESULT_DESER_FRAME_CHECK_EN
          if (count != 5'd0) err = 1'b1;
`endif
        end
      end
`ifdef RESULT_DESER_FRAME_CHECK_EN
      DRAIN: begin
        if (!recieve) state_nxt = IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath, result hand-off and status flags.
  always_ff @(posedge clk) begin
    if (!nRST) begin
      count        <= 5'd0;
      sr           <= 32'd0;
      C00          <= 8'd0;
      C01          <= 8'd0;
      C10          <= 8'd0;
      C11          <= 8'd0;
      result_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      count <= count_nxt;
      sr    <= sr_nxt;
      if (done) begin
        C00 <= sr_nxt[31:24];
        C01 <= sr_nxt[23:16];
        C10 <= sr_nxt[15:8];
        C11 <= sr_nxt[7:0];
      end
      if (done)            result_valid <= 1'b1;
      else if (result_ack) result_valid <= 1'b0;
      if (done && result_valid && !result_ack)
        overrun <= 1'b1;
    end
  end

`ifdef RESULT_DESER_FRAME_CHECK_EN
  // One-cycle malformed-frame pulse.
  always_ff @(posedge clk) begin
    if (!nRST) frame_err <= 1'b0;
    else       frame_err <= err;
  end
`else
  assign frame_err = 1'b0;
`endif

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_result_deserializer.sv
// Scoreboard bench for result_deserializer.
// Expected frames are queued at issue; a negedge monitor checks each load.
module tb_result_deserializer;
  logic       clk = 1'b0;
  logic       nRST = 1'b0;
  logic       serial_in = 1'b0;
  logic       recieve = 1'b0;
  logic       result_ack = 1'b0;
  logic [7:0] C00, C01, C10, C11;
  logic       result_valid, overrun, frame_err, busy;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic        rst_at_edge = 1'b1;

`ifdef RESULT_DESER_FRAME_CHECK_EN
  localparam logic FC = 1'b1;
`else
  localparam logic FC = 1'b0;
`endif

  result_deserializer dut (
    .clk(clk), .nRST(nRST), .serial_in(serial_in),
    .recieve(recieve), .result_ack(result_ack),
    .C00(C00), .C01(C01), .C10(C10), .C11(C11),
    .result_valid(result_valid), .overrun(overrun),
    .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rst_at_edge = !nRST;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends the first n bits of w, MSB first; ack optionally on the last bit.
  task automatic send_bits(input logic [31:0] w, input int n,
                           input logic ack_last);
    for (int i = 0; i < n; i++) begin
      recieve    = 1'b1;
      serial_in  = w[31-i];
      result_ack = (i == n-1) ? ack_last : 1'b0;
      tick();
    end
    result_ack = 1'b0;
  endtask

  task automatic idle();
    recieve    = 1'b0;
    serial_in  = 1'b0;
    result_ack = 1'b0;
    tick();
  endtask

  task automatic ack();
    recieve    = 1'b0;
    result_ack = 1'b1;
    tick();
    result_ack = 1'b0;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    tick();
    nRST = 1'b1;
  endtask

  function automatic logic [31:0] cword();
    return {C00, C01, C10, C11};
  endfunction

  // Monitor: any load of new result data pops one expected frame.
  initial begin
    logic [31:0] prev, cur, e;
    logic        prev_v;
    prev   = 32'd0;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      cur = cword();
      if (!rst_at_edge && (cur !== prev || (result_valid && !prev_v))) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_result: got %h expected none", cur);
        end else begin
          e = exp_q.pop_front();
          chk("result_data", cur, e);
          chk("result_valid_on_load", {31'd0, result_valid}, 32'd1);
        end
      end
      prev   = cur;
      prev_v = result_valid;
    end
  end

  initial begin
    tick();
    tick();
    chk("rst_C", cword(), 32'd0);
    chk("rst_flags", {28'd0, result_valid, overrun, frame_err, busy}, 32'd0);
    nRST = 1'b1;

    // Basic frame
    exp_q.push_back(32'h12A500FF);
    send_bits(32'h12A500FF, 32, 1'b0);
    chk("frame_valid", {31'd0, result_valid}, 32'd1);
    chk("frame_C", cword(), 32'h12A500FF);
    chk("frame_err_clean", {31'd0, frame_err}, 32'd0);
    idle();
    chk("frame_busy_low", {31'd0, busy}, 32'd0);
    ack();
    chk("ack_clears_valid", {31'd0, result_valid}, 32'd0);
    ack();
    chk("ack_ignored", {30'd0, result_valid, overrun}, 32'd0);

    // Short frame
    send_bits(32'h55555555, 10, 1'b0);
    chk("short_busy", {31'd0, busy}, 32'd1);
    idle();
    chk("short_busy_low", {31'd0, busy}, 32'd0);
    chk("short_err", {31'd0, frame_err}, {31'd0, FC});
    chk("short_valid", {31'd0, result_valid}, 32'd0);
    idle();
    chk("short_err_pulse", {31'd0, frame_err}, 32'd0);
    chk("short_C_kept", cword(), 32'h12A500FF);

    // Overrun
    exp_q.push_back(32'h01020304);
    send_bits(32'h01020304, 32, 1'b0);
    idle();
    chk("ovr_none_yet", {31'd0, overrun}, 32'd0);
    exp_q.push_back(32'h0A0B0C0D);
    send_bits(32'h0A0B0C0D, 32, 1'b0);
    idle();
    chk("ovr_C", cword(), 32'h0A0B0C0D);
    chk("ovr_flags", {30'd0, result_valid, overrun}, 32'd3);
    ack();
    chk("ovr_sticky", {30'd0, result_valid, overrun}, 32'd1);

    // Ack collision
    do_reset();
    chk("rst_clears_ovr", {31'd0, overrun}, 32'd0);
    exp_q.push_back(32'h11223344);
    send_bits(32'h11223344, 32, 1'b0);
    idle();
    exp_q.push_back(32'h55667788);
    send_bits(32'h55667788, 32, 1'b1);
    chk("coll_C", cword(), 32'h55667788);
    chk("coll_flags", {30'd0, result_valid, overrun}, 32'd2);
    idle();
    ack();

    // Reset mid-frame
    send_bits(32'hFFFFFFFF, 17, 1'b0);
    recieve = 1'b0;
    do_reset();
    chk("midrst_C", cword(), 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    exp_q.push_back(32'hDEADBEEF);
    send_bits(32'hDEADBEEF, 32, 1'b0);
    idle();
    chk("midrst_frame", cword(), 32'hDEADBEEF);
    ack();

    // Long frame
    exp_q.push_back(32'hCAFEF00D);
    send_bits(32'hCAFEF00D, 32, 1'b0);
    chk("long_valid", {31'd0, result_valid}, 32'd1);
    send_bits(32'hA5000000, 1, 1'b0);
    chk("long_err", {31'd0, frame_err}, {31'd0, FC});
    chk("long_busy33", {31'd0, busy}, 32'd1);
    send_bits(32'h4A000000, 7, 1'b0);
    chk("long_err_pulse", {31'd0, frame_err}, 32'd0);
    chk("long_busy40", {31'd0, busy}, 32'd1);
    idle();
    chk("long_busy_low", {31'd0, busy}, 32'd0);
    chk("long_err_end", {31'd0, frame_err}, 32'd0);
    chk("long_C_kept", cword(), 32'hCAFEF00D);
    idle();
    idle();
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/result_deserializer.md
RESULT_DESERIALIZER -- requirements
Module: result_deserializer

Interface
REQ-001 SHALL have port: clk  in  1  single rising-edge clock; one clock, reset is synchronous and active-low.
REQ-002 SHALL have port: nRST  in  1  synchronous active-low reset, sampled on rising clk.
REQ-003 SHALL have port: serial_in  in  1  result bitstream, MSB first, C00 then C01, C10, C11.
REQ-004 SHALL have port: recieve  in  1  frame enable; each clk with recieve=1 carries one data bit.
REQ-005 SHALL have port: result_ack  in  1  consumer accepts held result.
REQ-006 SHALL have ports: C00, C01, C10, C11  out  8 each  reconstructed result elements, registered.
REQ-007 SHALL have port: result_valid  out  1  level; held result is new and unacknowledged.
REQ-008 SHALL have port: overrun  out  1  sticky; a completed frame overwrote an unacknowledged result.
REQ-009 SHALL have port: frame_err  out  1  one-cycle pulse on a malformed frame.
REQ-010 SHALL have port: busy  out  1  high while a frame is partially received.

Function
REQ-011 SHALL implement states IDLE, SHIFT and DRAIN, plus a 5-bit bit counter and a 32-bit shift register.
REQ-012 IDLE: on recieve=1, SHALL capture serial_in as bit 31, set count=1 and go to SHIFT.
REQ-013 SHIFT: on recieve=1, SHALL shift serial_in into the LSB and increment count.
REQ-014 The 32nd sampled bit SHALL complete the frame.
- The same edge SHALL load C00=bits[31:24], C01=[23:16], C10=[15:8], C11=[7:0].
- The same edge SHALL set result_valid=1, so latency is zero cycles after the last bit edge.
- count SHALL then wrap to 0.
REQ-015 After completion with recieve still 1 on the next edge, behaviour SHALL be set by REQ-025/REQ-026.
- After completion with recieve=0, the block SHALL return to IDLE.
REQ-016 SHIFT with recieve=0 and count 1..31 (short frame): SHALL discard the partial data, return to IDLE and leave C outputs unchanged.
REQ-017 result_valid SHALL clear on the edge where result_ack=1, unless a frame completes on that same edge, in which case result_valid SHALL stay 1 with the new data.
REQ-018 A frame completing while result_valid=1 and result_ack=0 SHALL overwrite C outputs and set overrun=1.
- overrun SHALL clear only on reset.
REQ-019 result_ack while result_valid=0 SHALL be ignored.
REQ-020 busy SHALL be 1 iff state is SHIFT or DRAIN.
REQ-021 C outputs SHALL change only on frame completion or reset.

Reset
REQ-022 nRST=0 at a rising edge SHALL force state=IDLE, count=0, shift register=0, C00..C11=0, result_valid=0, overrun=0, frame_err=0, busy=0.
REQ-023 Reset mid-frame SHALL discard all partial bits.
- The first recieve=1 cycle after release SHALL be treated as bit 31 of a new frame.
REQ-024 Reset SHALL take priority over all simultaneous inputs.

Configuration
REQ-025 With macro RESULT_DESER_FRAME_CHECK_EN defined:
- A short frame (REQ-016) SHALL pulse frame_err for one cycle.
- recieve remaining 1 after a completed frame SHALL pulse frame_err and enter DRAIN.
- DRAIN SHALL ignore bits until recieve=0, then go to IDLE.
REQ-026 Without RESULT_DESER_FRAME_CHECK_EN:
- frame_err SHALL be tied to 0 and DRAIN SHALL be absent.
- Short frames SHALL be discarded silently.
- recieve remaining 1 after completion SHALL start a new frame, with the next bit as bit 31.

Verification
REQ-027 Frame: recieve=1 for 32 cycles carrying 0x12,0xA5,0x00,0xFF -> C00=0x12, C01=0xA5, C10=0x00, C11=0xFF; result_valid rises on the 32nd edge; frame_err=0.
REQ-028 Short frame: recieve=1 for 10 cycles, then 0 -> C outputs unchanged, result_valid=0, busy falls; frame_err pulses once only with the macro.
REQ-029 Overrun: two frames 0x01020304 then 0x0A0B0C0D with no ack -> C00..C11 = 0x0A,0x0B,0x0C,0x0D; result_valid=1; overrun=1.
REQ-030 Ack collision: result_ack=1 on the completion edge of a second frame -> result_valid stays 1 with the second frame's data; overrun=0.
REQ-031 Reset mid-frame: nRST=0 after bit 17, then a full frame 0xDEADBEEF -> C00=0xDE, C01=0xAD, C10=0xBE, C11=0xEF.
REQ-032 Long frame: recieve=1 for 40 cycles.
- With the macro: first 32 bits loaded, frame_err pulse, 8 bits ignored, busy=1 until recieve=0.
- Without the macro: 8 bits partially fill the next frame, then are discarded as a short frame.
